// File: rtl/array_10_arbiter.sv
// Round-robin two-requester arbiter and sequencer for the single-port array_10_ext macro.
// Define ARRAY10_ARB_INIT_EN to zero-fill all entries after reset before accepting requests.
module array_10_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 200,
  parameter int LANES  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*LANES-1:0]    req_mask,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            resp_valid,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  mem_en,
  output logic                  mem_wmode,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [LANES-1:0]      mem_wmask,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  init_done
);

  logic              rr_q, rr_d;
  logic              rd_v_q, rd_v_d;
  logic              rd_id_q, rd_id_d;
  logic              run;
  logic              init_drive;
  logic [ADDR_W-1:0] init_addr;
  logic              gnt_id;
  logic              fire;

  logic [ADDR_W-1:0] addr_a  [2];
  logic [LANES-1:0]  mask_a  [2];
  logic [DATA_W-1:0] wdata_a [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign addr_a[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign mask_a[gi]  = req_mask[gi*LANES +: LANES];
    assign wdata_a[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

`ifdef ARRAY10_ARB_INIT_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;

  assign run        = (state_q == ST_RUN);
  // Held-off while reset is asserted so the zero-fill only starts once reset is released.
  assign init_drive = (state_q == ST_INIT) && !reset;
  assign init_addr  = init_cnt_q;
  assign init_done  = run;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (init_drive) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == {ADDR_W{1'b1}}) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end
`else
  assign run        = 1'b1;
  assign init_drive = 1'b0;
  assign init_addr  = '0;
  assign init_done  = 1'b1;
`endif

  // A lone requester always wins; contention is broken by the round-robin pointer.
  always_comb begin
    gnt_id = (req_valid == 2'b11) ? rr_q : req_valid[1];
    fire   = run && (req_valid != 2'b00);
    if (fire) begin
      req_ready = gnt_id ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (init_drive) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = init_addr;
      mem_wmask = '1;
    end else if (fire) begin
      mem_en    = 1'b1;
      mem_wmode = req_write[gnt_id];
      mem_addr  = addr_a[gnt_id];
      mem_wmask = mask_a[gnt_id];
      mem_wdata = wdata_a[gnt_id];
    end
  end

  always_comb begin
    rr_d    = fire ? ~gnt_id : rr_q;
    rd_v_d  = fire && !req_write[gnt_id];
    rd_id_d = gnt_id;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q    <= 1'b0;
      rd_v_q  <= 1'b0;
      rd_id_q <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      rd_v_q  <= rd_v_d;
      rd_id_q <= rd_id_d;
    end
  end

  // Gating with reset drops a response whose read fired just before reset rose.
  assign resp_valid = {rd_v_q &&  rd_id_q && !reset,
                       rd_v_q && !rd_id_q && !reset};
  assign resp_data  = mem_rdata;

endmodule

// File: tb/tb_array_10_arbiter.sv
// Directed bench for array_10_arbiter with a behavioural array_10_ext model and response scoreboard.
// Build with ARRAY10_ARB_INIT_EN defined to also exercise the zero-fill sequence.
module tb_array_10_arbiter;
  localparam int AW = 3;
  localparam int DW = 200;
  localparam int LW = 2;
  localparam int LANE_W = DW / LW;

  logic            clock;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*LW-1:0] req_mask;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      resp_valid;
  logic [DW-1:0]   resp_data;
  logic            mem_en;
  logic            mem_wmode;
  logic [AW-1:0]   mem_addr;
  logic [LW-1:0]   mem_wmask;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            init_done;

  array_10_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LANES(LW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .init_done(init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural macro: registered read, lane-masked write.
  logic [DW-1:0] macro_mem [8];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wmode) begin
        for (int l = 0; l < LW; l++)
          if (mem_wmask[l]) macro_mem[mem_addr][l*LANE_W +: LANE_W] <= mem_wdata[l*LANE_W +: LANE_W];
      end else begin
        mem_rdata <= macro_mem[mem_addr];
      end
    end
  end

  typedef struct {
    logic [1:0]    v;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] ref_mem [8];
  int            n_vec;
  int            n_fail;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_resp(input string tag);
    exp_t e;
    if (sbq.size() > 0) e = sbq.pop_front();
    else begin e.v = 2'b00; e.d = '0; end
    chk({tag, " resp_valid"}, DW'(resp_valid), DW'(e.v));
    if (e.v != 2'b00) chk({tag, " resp_data"}, resp_data, e.d);
  endtask

  // One cycle: check the previous cycle's response, drive new requests, check grant and port drive.
  task automatic step(input logic [1:0] v, input logic [1:0] w,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [LW-1:0] m0, input logic [LW-1:0] m1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic [1:0] er, input string tag);
    exp_t          e;
    logic          gid;
    logic [AW-1:0] ga;
    logic [LW-1:0] gm;
    logic [DW-1:0] gd;
    @(negedge clock);
    check_resp(tag);
    req_valid = v;
    req_write = w;
    req_addr  = {a1, a0};
    req_mask  = {m1, m0};
    req_wdata = {d1, d0};
    #1;
    chk({tag, " req_ready"}, DW'(req_ready), DW'(er));
    e.v = 2'b00;
    e.d = '0;
    if (er != 2'b00) begin
      gid = er[1];
      ga  = gid ? a1 : a0;
      gm  = gid ? m1 : m0;
      gd  = gid ? d1 : d0;
      chk({tag, " mem_en"},    DW'(mem_en),    DW'(1'b1));
      chk({tag, " mem_wmode"}, DW'(mem_wmode), DW'(w[gid]));
      chk({tag, " mem_addr"},  DW'(mem_addr),  DW'(ga));
      chk({tag, " mem_wmask"}, DW'(mem_wmask), DW'(gm));
      chk({tag, " mem_wdata"}, mem_wdata, gd);
      if (w[gid]) begin
        for (int l = 0; l < LW; l++)
          if (gm[l]) ref_mem[ga][l*LANE_W +: LANE_W] = gd[l*LANE_W +: LANE_W];
      end else begin
        e.v = er;
        e.d = ref_mem[ga];
      end
    end else begin
      chk({tag, " mem_en idle"},   DW'(mem_en),    DW'(1'b0));
      chk({tag, " mem_addr idle"}, DW'(mem_addr),  DW'(3'd0));
      chk({tag, " mem_ctl idle"},  DW'({mem_wmode, mem_wmask}), DW'(3'd0));
      chk({tag, " mem_wdata idle"}, mem_wdata, '0);
    end
    sbq.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset     = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    #1;
    chk({tag, " resp_valid in reset"}, DW'(resp_valid), DW'(2'b00));
    sbq.delete();
    @(negedge clock);
    #1;
    chk({tag, " rst req_ready"}, DW'(req_ready), DW'(2'b00));
    chk({tag, " rst resp_valid"}, DW'(resp_valid), DW'(2'b00));
    chk({tag, " rst mem_en"}, DW'(mem_en), DW'(1'b0));
`ifdef ARRAY10_ARB_INIT_EN
    chk({tag, " rst init_done"}, DW'(init_done), DW'(1'b0));
`else
    chk({tag, " rst init_done"}, DW'(init_done), DW'(1'b1));
`endif
    @(negedge clock);
    reset = 1'b0;
`ifdef ARRAY10_ARB_INIT_EN
    for (int i = 0; i < 8; i++) begin
      req_valid = 2'b11;
      req_addr  = {3'd2, 3'd1};
      #1;
      chk($sformatf("%s init%0d mem_en", tag, i), DW'(mem_en), DW'(1'b1));
      chk($sformatf("%s init%0d mem_addr", tag, i), DW'(mem_addr), DW'(i));
      chk($sformatf("%s init%0d ctl", tag, i), DW'({mem_wmode, mem_wmask}), DW'(3'b111));
      chk($sformatf("%s init%0d wdata", tag, i), mem_wdata, '0);
      chk($sformatf("%s init%0d ready", tag, i), DW'({req_ready, init_done}), DW'(3'b000));
      @(negedge clock);
    end
    req_valid = 2'b00;
    #1;
    chk({tag, " init_done rise"}, DW'(init_done), DW'(1'b1));
    chk({tag, " post-init mem_en"}, DW'(mem_en), DW'(1'b0));
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
`else
    #1;
    chk({tag, " init_done"}, DW'(init_done), DW'(1'b1));
`endif
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int k = 0; k < DW; k++) r[k] = ($urandom() & 1) != 0;
    return r;
  endfunction

  logic [DW-1:0] dat_a, dat_b, dat_c, d1, d2, zz;

  initial begin
    n_vec = 0;
    n_fail = 0;
    reset = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr = '0;
    req_mask = '0;
    req_wdata = '0;
    zz = '0;
    dat_a = rnd();
    dat_b = rnd();
    dat_c = rnd();
    d1 = rnd();
    d2 = rnd();

    do_reset("por");
`ifdef ARRAY10_ARB_INIT_EN
    step(2'b01, 2'b00, 3'd5, 3'd0, 2'b00, 2'b00, zz, zz, 2'b01, "rd5 after init");
`endif
    // Write by requester 0 then read back by requester 1 on the next cycle.
    step(2'b01, 2'b01, 3'd3, 3'd0, 2'b11, 2'b00, dat_a, zz, 2'b01, "wr3 r0");
    step(2'b10, 2'b00, 3'd0, 3'd3, 2'b00, 2'b00, zz, zz, 2'b10, "rd3 r1");
    step(2'b10, 2'b10, 3'd0, 3'd1, 2'b00, 2'b11, zz, d1, 2'b10, "wr1 r1");
    step(2'b10, 2'b10, 3'd0, 3'd2, 2'b00, 2'b11, zz, d2, 2'b10, "wr2 r1");
    // Contention from rr=0 must alternate 0,1,0,1,0,1.
    for (int k = 0; k < 6; k++)
      step(2'b11, 2'b00, 3'd1, 3'd2, 2'b00, 2'b00, zz, zz,
           (k % 2 == 0) ? 2'b01 : 2'b10, $sformatf("contend%0d", k));
    // Partial and empty-mask writes on entry 4.
    step(2'b01, 2'b01, 3'd4, 3'd0, 2'b11, 2'b00, dat_b, zz, 2'b01, "wr4 full");
    step(2'b01, 2'b01, 3'd4, 3'd0, 2'b01, 2'b00, dat_c, zz, 2'b01, "wr4 lo");
    step(2'b01, 2'b00, 3'd4, 3'd0, 2'b00, 2'b00, zz, zz, 2'b01, "rd4 merge");
    step(2'b10, 2'b10, 3'd0, 3'd4, 2'b00, 2'b00, zz, dat_a, 2'b10, "wr4 mask00");
    step(2'b10, 2'b00, 3'd0, 3'd4, 2'b00, 2'b00, zz, zz, 2'b10, "rd4 unchanged");
    step(2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, zz, zz, 2'b00, "idle");
    // A read by requester 0 leaves rr=1; reset next cycle must drop the response and clear rr.
    step(2'b01, 2'b00, 3'd3, 3'd0, 2'b00, 2'b00, zz, zz, 2'b01, "rd3 pre-reset");
    do_reset("midrst");
    step(2'b11, 2'b00, 3'd1, 3'd2, 2'b00, 2'b00, zz, zz, 2'b01, "post-rst rr");
    step(2'b11, 2'b00, 3'd1, 3'd2, 2'b00, 2'b00, zz, zz, 2'b10, "post-rst rr2");
    step(2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, zz, zz, 2'b00, "flush");
    step(2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, zz, zz, 2'b00, "final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
